// File: rtl/adder_cmd_issuer_if.sv
// Console/adder connection bundle for adder_cmd_issuer; master is the issuer side.
interface adder_cmd_issuer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] adder_data;
  logic       adder_rdy;
  logic [7:0] r1;
  logic [7:0] r2;
  logic       subtract;
  logic       adder_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       err;

  modport master (
    input  rx_data, rx_valid, adder_data, adder_rdy,
    output r1, r2, subtract, adder_start, tx_data, tx_valid, busy, err
  );

  modport slave (
    output rx_data, rx_valid, adder_data, adder_rdy,
    input  r1, r2, subtract, adder_start, tx_data, tx_valid, busy, err
  );
endinterface

// File: rtl/adder_cmd_issuer.sv
// Parses "<hex><+|-><hex>" from the console, issues it to the adder and forwards the result character.
// Define ISSUER_ECHO_EN to echo each accepted digit/operator on tx the cycle after it arrives.
module adder_cmd_issuer #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  adder_cmd_issuer_if.master bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
`ifdef ISSUER_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [2:0] {GET_A, GET_OP, GET_B, ISSUE, WAIT} state_e;

  state_e        state_q, state_d;
  logic [7:0]    r1_q, r1_d;
  logic [7:0]    r2_q, r2_d;
  logic          sub_q, sub_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    hx;
  logic          is_esc, is_op, accept;

  // {is_hex, nibble}
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h00;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  assign hx     = hex_decode(bus.rx_data);
  assign is_esc = (bus.rx_data == CH_ESC);
  assign is_op  = (bus.rx_data == CH_PLUS) || (bus.rx_data == CH_MINUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GET_A;
      r1_q       <= 8'h00;
      r2_q       <= 8'h00;
      sub_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      sub_q      <= sub_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_A:  if (bus.rx_valid && !is_esc) state_d = hx[4] ? GET_OP : GET_A;
      GET_OP: if (bus.rx_valid) state_d = (is_op && !is_esc) ? GET_B : GET_A;
      GET_B:  if (bus.rx_valid) state_d = (hx[4] && !is_esc) ? ISSUE : GET_A;
      ISSUE:  state_d = WAIT;
      // A result on the expiry cycle still wins over the timeout
      WAIT:   if (bus.adder_rdy || cnt_q == CNT_LAST) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  always_comb begin
    r1_d       = r1_q;
    r2_d       = r2_q;
    sub_d      = sub_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    case (state_q)
      GET_A: if (bus.rx_valid && !is_esc) begin
        if (hx[4]) begin
          r1_d   = {4'h0, hx[3:0]};
          accept = 1'b1;
        end else err_d = 1'b1;
      end
      GET_OP: if (bus.rx_valid && !is_esc) begin
        if (is_op) begin
          sub_d  = (bus.rx_data == CH_MINUS);
          accept = 1'b1;
        end else err_d = 1'b1;
      end
      GET_B: if (bus.rx_valid && !is_esc) begin
        if (hx[4]) begin
          r2_d   = {4'h0, hx[3:0]};
          accept = 1'b1;
        end else err_d = 1'b1;
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        if (bus.adder_rdy) begin
          tx_data_d  = bus.adder_data;
          tx_valid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) err_d = 1'b1;
        else cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
    if (ECHO && accept) begin
      tx_data_d  = bus.rx_data;
      tx_valid_d = 1'b1;
    end
  end

  assign bus.r1          = r1_q;
  assign bus.r2          = r2_q;
  assign bus.subtract    = sub_q;
  assign bus.adder_start = (state_q == ISSUE);
  assign bus.busy        = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.err         = err_q;
endmodule

// File: doc/adder_cmd_issuer.md
ADDER_CMD_ISSUER -- requirements
Module: adder_cmd_issuer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max clk cycles to wait for adder ready after a start pulse.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  ASCII character from the console receiver.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid for this cycle, one-cycle pulse per character.
REQ-006 SHALL have port adder_data  input  8  ASCII result from the adder.
REQ-007 SHALL have port adder_rdy  input  1  adder result-ready pulse.
REQ-008 SHALL have port r1  output  8  operand A to the adder.
REQ-009 SHALL have port r2  output  8  operand B to the adder.
REQ-010 SHALL have port subtract  output  1  operation select, 1 = A minus B.
REQ-011 SHALL have port adder_start  output  1  one-cycle operands-ready pulse to the adder.
REQ-012 SHALL have port tx_data  output  8  character to the console transmitter.
REQ-013 SHALL have port tx_valid  output  1  tx_data valid, one-cycle pulse.
REQ-014 SHALL have port busy  output  1  high while in states ISSUE or WAIT.
REQ-015 SHALL have port err  output  1  one-cycle error pulse.

Function
REQ-016 SHALL implement states GET_A, GET_OP, GET_B, ISSUE, WAIT; GET_A follows reset.
REQ-017 SHALL treat '0'-'9', 'A'-'F', 'a'-'f' as hex digits, value 0-15.
REQ-018 SHALL, in GET_A on a hex digit with rx_valid, load r1 = {4'h0, nibble} at that edge and go to GET_OP.
REQ-019 SHALL, in GET_OP, on '+' (0x2B) set subtract=0 and on '-' (0x2D) set subtract=1, then go to GET_B.
REQ-020 SHALL, in GET_B on a hex digit, load r2 = {4'h0, nibble} and go to ISSUE.
REQ-021 SHALL assert adder_start for exactly the one cycle spent in ISSUE, which is the cycle after the GET_B digit edge, then go to WAIT.
REQ-022 SHALL, in WAIT, on adder_rdy capture adder_data into tx_data, pulse tx_valid on the next cycle, and return to GET_A.
REQ-023 SHALL, in WAIT, pulse err and return to GET_A if adder_rdy has not arrived after TIMEOUT cycles counted from the first WAIT cycle; tx_valid SHALL NOT pulse.
REQ-024 SHALL, on any non-matching character in GET_A/GET_OP/GET_B, pulse err the next cycle and go to GET_A, keeping r1/r2/subtract unchanged.
REQ-025 SHALL, on ESC (0x1B) in any GET state, go to GET_A without err.
REQ-026 SHALL ignore rx_valid in ISSUE and WAIT, with no error and no echo.
REQ-027 SHALL hold r1, r2, subtract stable from ISSUE until the next load.
REQ-028 SHALL ignore adder_rdy outside WAIT.
REQ-029 SHALL, if adder_rdy arrives on the cycle the timeout expires, treat it as a success: no err, result sent.

Reset
REQ-030 SHALL, on rst, set state GET_A, r1=r2=0, subtract=0, adder_start=0, tx_data=0, tx_valid=0, busy=0, err=0, and clear the timeout counter.
REQ-031 SHALL let rst in ISSUE or WAIT abort the operation, with no tx_valid pulse and no err pulse afterwards.

Configuration
REQ-032 SHALL, with ISSUER_ECHO_EN defined, pulse tx_valid the cycle after each accepted digit or operator, with tx_data equal to that character.
REQ-033 SHALL, without ISSUER_ECHO_EN, emit tx_valid only for results.
REQ-034 SHALL leave all other behaviour identical in both builds; result and echo never coincide because rx is ignored in WAIT.

Verification
REQ-035 SHALL cover: send '3','+','4' with an adder model whose rdy comes 5 cycles after start -> r1=0x03, r2=0x04, subtract=0, one start pulse, tx_data=0x37 with a single tx_valid.
REQ-036 SHALL cover: send 'a','-','2' -> r1=0x0A, r2=0x02, subtract=1, start pulses once.
REQ-037 SHALL cover: send '3','*' -> err pulse one cycle after '*', state GET_A, no start.
REQ-038 SHALL cover: valid command with rdy never asserted -> err exactly TIMEOUT+1 cycles after start, no tx_valid, busy low afterwards.
REQ-039 SHALL cover: rst asserted 2 cycles into WAIT with rdy arriving later -> all outputs at reset values, no tx_valid.
REQ-040 SHALL cover: build with ISSUER_ECHO_EN and send '1','+','1' -> echoes 0x31, 0x2B, 0x31, then the result character.
